// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one data-bus transaction per EX/MEM request,
// stalls the pipeline meanwhile, and hands extended load data to MEM/WB.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I_MemRead,
    input  logic                  I_MemWrite,
    input  logic [2:0]            I_funct3,
    input  logic [31:0]           I_addr,
    input  logic [DATA_WIDTH-1:0] I_storeData,
    output logic                  O_stall,
    output logic [DATA_WIDTH-1:0] O_memReadData,
    output logic                  O_done,
    output logic                  O_misalign,
    output logic                  O_busErr,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t                state, nextState;
    logic [7:0]            count;
    logic                  weReg;
    logic [31:0]           addrReg;
    logic [DATA_WIDTH-1:0] wdataReg;
    logic [3:0]            wstrbReg;
    logic [2:0]            funct3Reg;
    logic [1:0]            offsetReg;
    logic                  misalignReg;
    logic                  busErrReg;
    logic [DATA_WIDTH-1:0] readDataReg;

    logic                  request;
    logic                  start;
    logic                  misaligned;
    logic                  timedOut;
    logic [DATA_WIDTH-1:0] storeWdata;
    logic [3:0]            storeWstrb;
    logic [7:0]            loadByte;
    logic [15:0]           loadHalf;
    logic [DATA_WIDTH-1:0] loadData;

    // Start is gated by reset so the stall drops the moment reset asserts.
    assign request    = I_MemRead | I_MemWrite;
    assign start      = rst & (state == IDLE) & request;
    assign misaligned = ((I_funct3[1:0] == 2'b01) && I_addr[0]) ||
                        ((I_funct3[1:0] == 2'b10) && (I_addr[1:0] != 2'b00));
    assign timedOut   = (count == LAST_WAIT);

    assign O_stall       = start | (state == REQ);
    assign O_done        = (state == DONE);
    assign O_misalign    = misalignReg;
    assign O_busErr      = busErrReg;
    assign O_memReadData = readDataReg;
    assign bus_req       = (state == REQ);
    assign bus_we        = weReg;
    assign bus_addr      = addrReg;
    assign bus_wdata     = wdataReg;
    assign bus_wstrb     = wstrbReg;

    always_comb begin
        storeWdata = I_storeData;
        storeWstrb = 4'b1111;
        case (I_funct3)
            3'b000: begin
                storeWdata = {4{I_storeData[7:0]}};
                storeWstrb = 4'b0001 << I_addr[1:0];
            end
            3'b001: begin
                storeWdata = {2{I_storeData[15:0]}};
                storeWstrb = 4'b0011 << {I_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        loadByte = bus_rdata[{offsetReg, 3'b000} +: 8];
        loadHalf = bus_rdata[{offsetReg[1], 4'b0000} +: 16];
        loadData = bus_rdata;
        case (funct3Reg)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'b0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'b0, loadHalf};
            default: ;
        endcase
    end

    // An ack in the final wait cycle takes priority over the timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (request) nextState = misaligned ? DONE : REQ;
            REQ:     if (bus_ack || timedOut) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            weReg       <= 1'b0;
            addrReg     <= '0;
            wdataReg    <= '0;
            wstrbReg    <= '0;
            funct3Reg   <= '0;
            offsetReg   <= '0;
            misalignReg <= 1'b0;
            busErrReg   <= 1'b0;
            readDataReg <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (request) begin
                        misalignReg <= misaligned;
                        busErrReg   <= 1'b0;
                        if (!misaligned) begin
                            weReg     <= I_MemWrite;
                            addrReg   <= {I_addr[31:2], 2'b00};
                            wdataReg  <= storeWdata;
                            wstrbReg  <= I_MemWrite ? storeWstrb : 4'b0000;
                            funct3Reg <= I_funct3;
                            offsetReg <= I_addr[1:0];
                            count     <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        busErrReg <= bus_err;
                        if (!weReg) readDataReg <= bus_err ? '0 : loadData;
                    end else begin
                        count <= count + 8'd1;
                        if (timedOut) begin
                            busErrReg <= 1'b1;
                            if (!weReg) readDataReg <= '0;
                        end
                    end
                end
                DONE: begin
                    misalignReg <= 1'b0;
                    busErrReg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
